// File: rtl/da_fir_sequencer_pkg.sv
// Shared types and sizing helpers for the distributed-arithmetic FIR sequencer.
package da_fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } da_seq_state_t;

    localparam int DEFAULT_WORD_WIDTH = 16;
    localparam int DEFAULT_NUM_SUB    = 2;

    // One growth bit per doubling of the number of summed subfilter words.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    function automatic int bit_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(DEFAULT_WORD_WIDTH);
    localparam int SUM_WIDTH = sum_width(DEFAULT_WORD_WIDTH, DEFAULT_NUM_SUB);

endpackage

// File: rtl/da_fir_sequencer_if.sv
// Sample input, subfilter strobe/collection and result output bundle of the sequencer.
interface da_fir_sequencer_if
    import da_fir_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int NUM_SUB    = DEFAULT_NUM_SUB
);
    localparam int SW = sum_width(WORD_WIDTH, NUM_SUB);

    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_WIDTH-1:0]         in_data;
    logic                          x_we;
    logic [WORD_WIDTH-1:0]         x;
    logic                          en;
    logic                          ts;
    logic [NUM_SUB*WORD_WIDTH-1:0] y_sub;
    logic                          out_valid;
    logic                          out_ready;
    logic [SW-1:0]                 out_data;

    modport master (
        output in_valid, in_data, y_sub, out_ready,
        input  in_ready, x_we, x, en, ts, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, y_sub, out_ready,
        output in_ready, x_we, x, en, ts, out_valid, out_data
    );

endinterface

// File: rtl/da_fir_sequencer_adder_tree.sv
// Combinational signed reduction of the packed subfilter y words, wrapping at SUM_WIDTH.
module da_adder_tree #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_SUB    = 2,
    parameter int SUM_WIDTH  = 17
) (
    input  logic [NUM_SUB*WORD_WIDTH-1:0] y,
    output logic [SUM_WIDTH-1:0]          sum
);

    // Accumulate every slice after sign extension to the result width.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_SUB; k++) begin
            sum = sum + SUM_WIDTH'($signed(y[k*WORD_WIDTH +: WORD_WIDTH]));
        end
    end

endmodule

// File: rtl/da_fir_sequencer.sv
// Drives one word-serial pass of the DA subfilter chain per sample and collects
// the summed subfilter outputs on the sign-bit cycle.
module da_fir_sequencer
    import da_fir_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int NUM_SUB    = DEFAULT_NUM_SUB
) (
    input  logic               clk,
    input  logic               rst,
    da_fir_sequencer_if.slave  bus
);

    localparam int SW    = sum_width(WORD_WIDTH, NUM_SUB);
    localparam int CNT_W = bit_cnt_width(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    da_seq_state_t          state_r;
    da_seq_state_t          state_s;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [WORD_WIDTH-1:0]  x_r;
    logic [SW-1:0]          out_data_r;
    logic                   out_valid_r;
    logic [SW-1:0]          sum_s;
    logic                   last_s;
    logic                   accept_s;
    logic                   in_ready_s;
    logic                   x_we_s;
    logic                   en_s;
    logic                   ts_s;

    da_adder_tree #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_SUB    (NUM_SUB),
        .SUM_WIDTH  (SW)
    ) u_adder_tree (
        .y   (bus.y_sub),
        .sum (sum_s)
    );

    assign last_s   = (bit_cnt_r == LAST_BIT);
    assign accept_s = bus.in_valid & in_ready_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; DONE hands straight to LOAD when a new sample is waiting.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? LOAD : IDLE;
            LOAD:    state_s = RUN;
            RUN:     state_s = last_s ? DONE : RUN;
            DONE: begin
                if (bus.out_ready) begin
                    state_s = bus.in_valid ? LOAD : IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Strobe decode from the registered state only.
    always_comb begin
        in_ready_s = 1'b0;
        x_we_s     = 1'b0;
        en_s       = 1'b0;
        ts_s       = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            LOAD:    x_we_s     = 1'b1;
            RUN: begin
                en_s = 1'b1;
                ts_s = last_s;
            end
            DONE:    in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Sample capture, bit counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r         <= '0;
            bit_cnt_r   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                x_r <= bus.in_data;
            end else begin
                x_r <= x_r;
            end
            if (state_r == LOAD) begin
                bit_cnt_r <= '0;
            end else if (state_r == RUN) begin
                bit_cnt_r <= last_s ? '0 : bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if ((state_r == RUN) && last_s) begin
                out_data_r  <= sum_s;
                out_valid_r <= 1'b1;
            end else if ((state_r == DONE) && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.x_we      = x_we_s;
    assign bus.x         = x_r;
    assign bus.en        = en_s;
    assign bus.ts        = ts_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_da_fir_sequencer.sv
// Scoreboard bench for da_fir_sequencer with WORD_WIDTH=16, NUM_SUB=2.
module tb_da_fir_sequencer;
    import da_fir_pkg::*;

    localparam int W  = 16;
    localparam int N  = 2;
    localparam int SW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    da_fir_sequencer_if #(.WORD_WIDTH(W), .NUM_SUB(N)) bus ();

    da_fir_sequencer #(.WORD_WIDTH(W), .NUM_SUB(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap = 0;
    logic [SW-1:0] exp_q[$];
    logic [W-1:0]  x_exp;
    logic [SW-1:0] last_out;
    logic [SW-1:0] want;
    int            valid_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && ((bus.x_we && bus.en) || (bus.ts && !bus.en))) overlap <= overlap + 1;
    end

    function automatic logic [SW-1:0] exp_sum(input logic [N*W-1:0] y);
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        a = {y[W-1], y[W-1:0]};
        b = {y[2*W-1], y[2*W-1:W]};
        return a + b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] d, input logic [N*W-1:0] y, input logic [SW-1:0] e);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.y_sub    = y;
        exp_q.push_back(e);
        x_exp = d;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
    endtask

    // Called just after the accept edge; ends in the DONE cycle with the result checked.
    task automatic check_pass(input string name);
        checks++;
        if (bus.x_we !== 1'b1 || bus.en !== 1'b0 || bus.x !== x_exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_load: x_we=%b en=%b x=%h in_ready=%b out_valid=%b, want 1 0 %h 0 0",
                     name, bus.x_we, bus.en, bus.x, bus.in_ready, bus.out_valid, x_exp);
        end
        for (int c = 0; c < W; c++) begin
            step();
            checks++;
            if (bus.en !== 1'b1 || bus.x_we !== 1'b0 || bus.ts !== (c == W - 1) || bus.out_valid !== 1'b0 || bus.x !== x_exp) begin
                errors++;
                $display("FAIL %s_run bit %0d: en=%b x_we=%b ts=%b out_valid=%b x=%h, want 1 0 %b 0 %h",
                         name, c, bus.en, bus.x_we, bus.ts, bus.out_valid, bus.x, (c == W - 1), x_exp);
            end
        end
        step();
        valid_cyc = cyc;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.en !== 1'b0 || bus.ts !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: out_valid=%b en=%b ts=%b, want 1 0 0", name, bus.out_valid, bus.en, bus.ts);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: queue empty at result, want one entry", name);
        end else begin
            want = exp_q.pop_front();
            if (bus.out_data !== want) begin
                errors++;
                $display("FAIL %s_data: out_data=%h, want %h", name, bus.out_data, want);
            end
        end
        last_out = bus.out_data;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.y_sub     = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.en !== 1'b0 || bus.ts !== 1'b0 ||
            bus.x_we !== 1'b0 || bus.out_data !== 17'h00000 || bus.x !== 16'h0000) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b en=%b ts=%b x_we=%b out_data=%h x=%h, want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.en, bus.ts, bus.x_we, bus.out_data, bus.x);
        end
        step();
    endtask

    task automatic test_latency();
        logic [N*W-1:0] y;
        y = {16'h0102, 16'h0304};
        accept(16'h1234, y, exp_sum(y));
        check_pass("latency");
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_idle: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_arith();
        logic [N*W-1:0] y;
        accept(16'h8001, {16'h8000, 16'h8000}, 17'h10000);
        check_pass("arith_minneg");
        step();
        accept(16'h0007, {16'h0003, 16'hFFFF}, 17'h00002);
        check_pass("arith_mixed");
        step();
        accept(16'h7FFF, {16'h7FFF, 16'h7FFF}, 17'h0FFFE);
        check_pass("arith_maxpos");
        step();
        for (int i = 0; i < 3; i++) begin
            y = {16'($urandom), 16'($urandom)};
            accept(16'($urandom), y, exp_sum(y));
            check_pass("arith_rand");
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] y;
        bus.out_ready = 1'b0;
        y = {16'hFFF0, 16'h0100};
        accept(16'h5A5A, y, exp_sum(y));
        check_pass("bp_first");
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== last_out || bus.in_ready !== 1'b0 || bus.en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold %0d: out_valid=%b out_data=%h in_ready=%b en=%b, want 1 %h 0 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, bus.en, last_out);
            end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hC3C3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_follow: in_ready=%b, want 1", bus.in_ready);
        end
        y = {16'h0011, 16'h8022};
        bus.y_sub = y;
        exp_q.push_back(exp_sum(y));
        x_exp = 16'hC3C3;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
        check_pass("bp_second");
        step();
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] y;
        int prev_valid;
        prev_valid = 0;
        y = {16'h1000, 16'h2000};
        accept(16'h0001, y, exp_sum(y));
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            check_pass("b2b");
            if (i > 0) begin
                checks++;
                if (valid_cyc - prev_valid != W + 2) begin
                    errors++;
                    $display("FAIL b2b_period: %0d cycles between results, want %0d", valid_cyc - prev_valid, W + 2);
                end
            end
            prev_valid = valid_cyc;
            if (i < 2) begin
                y = {16'(16'hF000 + i), 16'(16'h0F00 * (i + 1))};
                bus.y_sub   = y;
                bus.in_data = 16'(16'h0010 + i);
                x_exp       = bus.in_data;
                exp_q.push_back(exp_sum(y));
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N*W-1:0] y;
        y = {16'h0F0F, 16'h7070};
        accept(16'hA5A5, y, exp_sum(y));
        repeat (8) step();
        checks++;
        if (bus.en !== 1'b1 || bus.ts !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: en=%b ts=%b, want 1 0", bus.en, bus.ts);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.en !== 1'b0 || bus.ts !== 1'b0 || bus.x_we !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 17'h00000) begin
            errors++;
            $display("FAIL rst_mid: en=%b ts=%b x_we=%b out_valid=%b out_data=%h, want 0 0 0 0 0",
                     bus.en, bus.ts, bus.x_we, bus.out_valid, bus.out_data);
        end
        exp_q.delete();
        repeat (2) step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: out_valid=%b, want 0", bus.out_valid);
        end
        rst = 1'b0;
        step();
        y = {16'h8000, 16'h0001};
        accept(16'h3C3C, y, exp_sum(y));
        check_pass("rst_recover");
        step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL strobe_overlap: %0d cycles with x_we&en or ts&!en, want 0", overlap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
